// File: rtl/pic_pkg.sv
// Shared definitions for the PIC in-service/acknowledge path: FSM states,
// OCW2 command encodings and priority helpers.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } pic_state_t;

  // OCW2 {R, SL, EOI}
  localparam logic [2:0] OCW2_CLR_RAEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI    = 3'b001;
  localparam logic [2:0] OCW2_NOP       = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI    = 3'b011;
  localparam logic [2:0] OCW2_SET_RAEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS    = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI   = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP    = 3'b111;

  localparam logic [2:0] LP_RESET = 3'd7;

  function automatic logic [7:0] level_mask(input logic [2:0] lvl);
    level_mask = 8'd1 << lvl;
  endfunction

  // Rank 0 is the highest priority, i.e. the level just above lp.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
    prio_rank = lvl - lp - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Finds the highest-priority set bit of an 8-bit vector under a rotating
// lowest-priority pointer; level reads 7 when the vector is empty.
module priority_resolver (
  input  logic [7:0] vec,
  input  logic [2:0] lp,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] idx_s;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    valid = 1'b0;
    level = 3'd7;
    idx_s = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx_s = lp + 3'(i);
      if (vec[idx_s]) begin
        valid = 1'b1;
        level = idx_s;
      end else begin
        level = level;
      end
    end
  end

endmodule

// File: rtl/in_service_ctrl.sv
// 8259-style in-service and acknowledge controller: INTA sequencing, ISR,
// OCW2 EOI/rotation handling and vector byte generation.
module in_service_ctrl
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic       inta_n,
  input  logic       eoi_valid,
  input  logic [2:0] eoi_cmd,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] isr,
  output logic       reset_irr_bit,
  output logic [7:0] data_out,
  output logic       data_oe
);

  pic_state_t state_r;
  logic [2:0] lp_r, w_r, lp_next_s;
  logic [7:0] isr_r, set_s, clr_s, data_out_r;
  logic       raeoi_r, raeoi_next_s, inta_q_r, int_out_r, rib_r, data_oe_r;
  logic       irr_valid_s, isr_valid_s, fall_s, rise_s;
  logic [2:0] irr_level_s, isr_level_s;

  priority_resolver u_irr_res (.vec(irr),   .lp(lp_r), .valid(irr_valid_s), .level(irr_level_s));
  priority_resolver u_isr_res (.vec(isr_r), .lp(lp_r), .valid(isr_valid_s), .level(isr_level_s));

  assign fall_s = inta_q_r & ~inta_n;
  assign rise_s = ~inta_q_r & inta_n;

  // ISR set/clear masks and next pointer/mode from INTA, AEOI and OCW2.
  always_comb begin
    set_s        = 8'd0;
    clr_s        = 8'd0;
    lp_next_s    = lp_r;
    raeoi_next_s = raeoi_r;
    if (state_r == IDLE && fall_s && irr_valid_s) begin
      set_s = level_mask(irr_level_s);
    end else begin
      set_s = 8'd0;
    end
    if (state_r == ACK2 && rise_s && aeoi) begin
      clr_s = level_mask(w_r);
      if (raeoi_r) begin
        lp_next_s = w_r;
      end else begin
        lp_next_s = lp_r;
      end
    end else begin
      clr_s = 8'd0;
    end
    // OCW2 is evaluated against the pre-edge ISR.
    if (eoi_valid) begin
      case (eoi_cmd)
        OCW2_NS_EOI: begin
          if (isr_valid_s) clr_s = clr_s | level_mask(isr_level_s);
          else             clr_s = clr_s;
        end
        OCW2_SP_EOI: clr_s = clr_s | level_mask(eoi_level);
        OCW2_ROT_NS: begin
          if (isr_valid_s) begin
            clr_s     = clr_s | level_mask(isr_level_s);
            lp_next_s = isr_level_s;
          end else begin
            clr_s = clr_s;
          end
        end
        OCW2_ROT_SP: begin
          clr_s     = clr_s | level_mask(eoi_level);
          lp_next_s = eoi_level;
        end
        OCW2_SET_PRI:   lp_next_s    = eoi_level;
        OCW2_SET_RAEOI: raeoi_next_s = 1'b1;
        OCW2_CLR_RAEOI: raeoi_next_s = 1'b0;
        OCW2_NOP:       clr_s        = clr_s;
        default:        clr_s        = clr_s;
      endcase
    end else begin
      clr_s = clr_s;
    end
  end

  // Acknowledge FSM plus ISR, priority state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      lp_r       <= LP_RESET;
      raeoi_r    <= 1'b0;
      isr_r      <= 8'd0;
      w_r        <= 3'd7;
      inta_q_r   <= 1'b1;
      int_out_r  <= 1'b0;
      rib_r      <= 1'b0;
      data_oe_r  <= 1'b0;
      data_out_r <= 8'd0;
    end else begin
      inta_q_r  <= inta_n;
      isr_r     <= (isr_r & ~clr_s) | set_s;
      lp_r      <= lp_next_s;
      raeoi_r   <= raeoi_next_s;
      int_out_r <= irr_valid_s &&
                   (!isr_valid_s || (prio_rank(irr_level_s, lp_r) < prio_rank(isr_level_s, lp_r)));
      rib_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= ACK1;
            w_r     <= irr_level_s;
            rib_r   <= irr_valid_s;
          end
        end
        ACK1: begin
          if (rise_s) state_r <= WAIT2;
        end
        WAIT2: begin
          if (fall_s) begin
            state_r    <= ACK2;
            data_oe_r  <= 1'b1;
            data_out_r <= {vector_base, w_r};
          end
        end
        ACK2: begin
          if (rise_s) begin
            state_r    <= IDLE;
            data_oe_r  <= 1'b0;
            data_out_r <= 8'd0;
          end
        end
        default: begin
          state_r    <= IDLE;
          data_oe_r  <= 1'b0;
          data_out_r <= 8'd0;
        end
      endcase
    end
  end

  assign int_out       = int_out_r;
  assign isr           = isr_r;
  assign reset_irr_bit = rib_r;
  assign data_out      = data_out_r;
  assign data_oe       = data_oe_r;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Directed bench for in_service_ctrl; expected values are hand-computed.
module tb_in_service_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr;
  logic       inta_n;
  logic       eoi_valid;
  logic [2:0] eoi_cmd;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] isr;
  logic       reset_irr_bit;
  logic [7:0] data_out;
  logic       data_oe;

  int n_checks = 0;
  int n_pass   = 0;

  in_service_ctrl dut (
    .clk(clk), .reset(reset), .irr(irr), .inta_n(inta_n),
    .eoi_valid(eoi_valid), .eoi_cmd(eoi_cmd), .eoi_level(eoi_level),
    .aeoi(aeoi), .vector_base(vector_base), .int_out(int_out), .isr(isr),
    .reset_irr_bit(reset_irr_bit), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_cmd   = cmd;
    eoi_level = lvl;
    cyc(1);
    eoi_valid = 1'b0;
  endtask

  // Full two-pulse INTA; irr switches to irr_after once the level is frozen.
  task automatic inta_seq(input string tag, input logic [7:0] exp_isr1, input logic exp_rib,
                          input logic [7:0] irr_after, input logic [7:0] exp_vec,
                          input logic [7:0] exp_isr2);
    inta_n = 1'b0;
    cyc(1);
    check({tag, "_isr_fall1"}, isr, exp_isr1);
    check({tag, "_rib_pulse"}, 8'(reset_irr_bit), 8'(exp_rib));
    irr = irr_after;
    cyc(1);
    check({tag, "_rib_drop"}, 8'(reset_irr_bit), 8'd0);
    inta_n = 1'b1;
    cyc(1);
    check({tag, "_oe_ack1"}, 8'(data_oe), 8'd0);
    inta_n = 1'b0;
    cyc(1);
    check({tag, "_oe_ack2"}, 8'(data_oe), 8'd1);
    check({tag, "_vector"}, data_out, exp_vec);
    cyc(1);
    check({tag, "_oe_hold"}, 8'(data_oe), 8'd1);
    inta_n = 1'b1;
    cyc(1);
    check({tag, "_oe_drop"}, 8'(data_oe), 8'd0);
    check({tag, "_isr_end"}, isr, exp_isr2);
  endtask

  initial begin
    reset       = 1'b1;
    irr         = 8'h00;
    inta_n      = 1'b1;
    eoi_valid   = 1'b0;
    eoi_cmd     = 3'b010;
    eoi_level   = 3'd0;
    aeoi        = 1'b0;
    vector_base = 5'h08;
    cyc(2);
    check("rst_int_out", 8'(int_out), 8'd0);
    check("rst_isr", isr, 8'h00);
    check("rst_rib", 8'(reset_irr_bit), 8'd0);
    check("rst_oe", 8'(data_oe), 8'd0);
    check("rst_data", data_out, 8'h00);
    reset = 1'b0;
    cyc(1);

    // Basic acknowledge of IR2 out of 0x24; later irr change must not move W.
    irr = 8'h24;
    cyc(1);
    check("t1_int_out", 8'(int_out), 8'd1);
    inta_seq("t1", 8'h04, 1'b1, 8'h20, 8'h42, 8'h04);

    // Lower-priority request does not interrupt; IR0 does.
    irr = 8'h08;
    cyc(1);
    check("t2_int_low", 8'(int_out), 8'd0);
    irr = 8'h09;
    cyc(1);
    check("t2_int_high", 8'(int_out), 8'd1);
    irr = 8'h00;
    ocw2(3'b001, 3'd0);
    check("t2_ns_eoi", isr, 8'h00);
    ocw2(3'b001, 3'd0);
    check("t2_ns_eoi_empty", isr, 8'h00);

    // Auto-EOI with rotation: IR3 then lp=3 so IR4 beats IR0.
    aeoi = 1'b1;
    ocw2(3'b100, 3'd0);
    irr = 8'h08;
    cyc(1);
    inta_seq("t3", 8'h08, 1'b1, 8'h00, 8'h43, 8'h00);
    aeoi = 1'b0;
    irr  = 8'h11;
    cyc(1);
    inta_seq("t3r", 8'h10, 1'b1, 8'h01, 8'h44, 8'h10);
    ocw2(3'b011, 3'd4);
    check("t3_sp_eoi", isr, 8'h00);
    ocw2(3'b000, 3'd0);

    // Set priority lp=2: IR3 beats IR0.
    ocw2(3'b110, 3'd2);
    irr = 8'h09;
    cyc(1);
    inta_seq("t4", 8'h08, 1'b1, 8'h01, 8'h43, 8'h08);
    check("t4_int_lower", 8'(int_out), 8'd0);
    ocw2(3'b111, 3'd3);
    check("t4_rot_sp", isr, 8'h00);
    cyc(1);
    check("t4_int_after_eoi", 8'(int_out), 8'd1);
    ocw2(3'b110, 3'd7);

    // Spurious acknowledge.
    irr = 8'h00;
    cyc(1);
    inta_seq("t5", 8'h00, 1'b0, 8'h00, 8'h47, 8'h00);

    // EOI on the same edge as the first fall, then reset during WAIT2.
    irr = 8'h01;
    cyc(1);
    inta_seq("t6", 8'h01, 1'b1, 8'h00, 8'h40, 8'h01);
    irr       = 8'h04;
    inta_n    = 1'b0;
    eoi_valid = 1'b1;
    eoi_cmd   = 3'b001;
    cyc(1);
    eoi_valid = 1'b0;
    check("t6_eoi_and_set", isr, 8'h04);
    check("t6_rib", 8'(reset_irr_bit), 8'd1);
    cyc(1);
    inta_n = 1'b1;
    cyc(1);
    reset = 1'b1;
    #1;
    check("t6_rst_isr", isr, 8'h00);
    check("t6_rst_int", 8'(int_out), 8'd0);
    check("t6_rst_oe", 8'(data_oe), 8'd0);
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_rib", 8'(reset_irr_bit), 8'd0);
    inta_n = 1'b0;
    cyc(2);
    check("t6_rst_hold_oe", 8'(data_oe), 8'd0);
    reset  = 1'b0;
    inta_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
